// File: rtl/pi_req_queue.sv
// Pi-to-68k request queue: staging registers, request FIFO and a bus-cycle issue FSM.
// Optional macro PI_REQ_LONG_SPLIT_EN enables splitting longword requests into two word cycles.
module pi_req_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 24
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     pi_wr_stb,
  input  logic [2:0]               pi_reg,
  input  logic [15:0]              pi_wdata,
  output logic                     bus_req_valid,
  input  logic                     bus_req_ready,
  output logic [AW-1:0]            bus_req_addr,
  output logic                     bus_req_read,
  output logic [1:0]               bus_req_size,
  output logic [2:0]               bus_req_fc,
  output logic [15:0]              bus_req_wdata,
  input  logic                     bus_done,
  input  logic [15:0]              bus_rdata,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     q_empty,
  output logic                     q_full,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic                     busy,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]    fc;
    logic          read;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   stage_data_reg;
  logic [15:0]   stage_addr_reg;
  logic [PW:0]   wr_ptr_reg, rd_ptr_reg;
  entry_t        fifo_mem [DEPTH];
  entry_t        commit_entry, head;
  logic          commit, push, pop, head_long;
  logic          overflow_reg;

  logic [AW-1:0] w_addr_reg;
  logic [15:0]   w_wdata_reg, w_data_lo_reg;
  logic [2:0]    w_fc_reg;
  logic          w_read_reg, w_byte_reg, w_long_reg, w_phase_reg;
  logic [31:0]   rd_data_reg;
  logic          rd_valid_reg;
  logic          unused_wdata;

  assign unused_wdata = &{1'b0, pi_wdata[15:14]};

  assign commit = pi_wr_stb && (pi_reg == 3'd3);
  assign pop    = (state_reg == S_IDLE) && !q_empty;
  // A full FIFO can still accept a commit when the head leaves in the same cycle.
  assign push   = commit && (!q_full || pop);

  assign commit_entry.fc   = pi_wdata[13:11];
  assign commit_entry.read = pi_wdata[10];
  assign commit_entry.size = pi_wdata[9:8];
  assign commit_entry.addr = AW'({pi_wdata[7:0], stage_addr_reg});
  assign commit_entry.data = stage_data_reg;

  assign head = fifo_mem[rd_ptr_reg[PW-1:0]];

`ifdef PI_REQ_LONG_SPLIT_EN
  assign head_long = (head.size == 2'd2);
`else
  assign head_long = 1'b0;
`endif

  assign q_level = wr_ptr_reg - rd_ptr_reg;
  assign q_empty = (wr_ptr_reg == rd_ptr_reg);
  assign q_full  = (q_level == (PW+1)'(DEPTH));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stage_data_reg <= '0;
      stage_addr_reg <= '0;
      overflow_reg   <= 1'b0;
    end else if (pi_wr_stb) begin
      case (pi_reg)
        3'd0: stage_data_reg[15:0]  <= pi_wdata;
        3'd1: stage_data_reg[31:16] <= pi_wdata;
        3'd2: stage_addr_reg        <= pi_wdata;
        3'd3: if (!push) overflow_reg <= 1'b1;
        3'd5: overflow_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr_reg[PW-1:0]] <= commit_entry;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_reg <= S_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (!q_empty) state_next = S_ISSUE;
      S_ISSUE: if (bus_req_ready) state_next = S_WAIT;
      S_WAIT:  if (bus_done) state_next = (w_long_reg && !w_phase_reg) ? S_ISSUE : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_valid = (state_reg == S_ISSUE);
    busy          = (state_reg != S_IDLE) || !q_empty;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      w_addr_reg    <= '0;
      w_wdata_reg   <= '0;
      w_data_lo_reg <= '0;
      w_fc_reg      <= '0;
      w_read_reg    <= 1'b0;
      w_byte_reg    <= 1'b0;
      w_long_reg    <= 1'b0;
      w_phase_reg   <= 1'b0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
    end else if (pop) begin
      // Longwords start with the high word at the even address.
      w_addr_reg    <= head_long ? {head.addr[AW-1:1], 1'b0} : head.addr;
      w_wdata_reg   <= head_long ? head.data[31:16] : head.data[15:0];
      w_data_lo_reg <= head.data[15:0];
      w_fc_reg      <= head.fc;
      w_read_reg    <= head.read;
      w_byte_reg    <= (head.size == 2'd0);
      w_long_reg    <= head_long;
      w_phase_reg   <= 1'b0;
      if (head.read) rd_valid_reg <= 1'b0;
    end else if (state_reg == S_WAIT && bus_done) begin
      if (w_long_reg && !w_phase_reg) begin
        w_phase_reg <= 1'b1;
        w_addr_reg  <= w_addr_reg + AW'(2);
        w_wdata_reg <= w_data_lo_reg;
        if (w_read_reg) rd_data_reg[31:16] <= bus_rdata;
      end else if (w_read_reg) begin
        rd_data_reg[15:0] <= bus_rdata;
        if (!w_long_reg) rd_data_reg[31:16] <= '0;
        rd_valid_reg <= 1'b1;
      end
    end
  end

  assign bus_req_addr  = w_addr_reg;
  assign bus_req_read  = w_read_reg;
  assign bus_req_size  = w_byte_reg ? 2'd0 : 2'd1;
  assign bus_req_fc    = w_fc_reg;
  assign bus_req_wdata = w_wdata_reg;
  assign rd_data       = rd_data_reg;
  assign rd_valid      = rd_valid_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_pi_req_queue.sv
// Directed self-checking bench for pi_req_queue: decode table plus longword, overflow and reset sequences.
module tb_pi_req_queue;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        pi_wr_stb;
  logic [2:0]  pi_reg;
  logic [15:0] pi_wdata;
  logic        bus_req_valid, bus_req_ready;
  logic [23:0] bus_req_addr;
  logic        bus_req_read;
  logic [1:0]  bus_req_size;
  logic [2:0]  bus_req_fc;
  logic [15:0] bus_req_wdata;
  logic        bus_done;
  logic [15:0] bus_rdata;
  logic [31:0] rd_data;
  logic        rd_valid, q_empty, q_full, busy, overflow;
  logic [2:0]  q_level;

  int n_vec = 0;
  int n_bad = 0;

  pi_req_queue #(.DEPTH(4), .AW(24)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_wr_stb(pi_wr_stb), .pi_reg(pi_reg), .pi_wdata(pi_wdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_read(bus_req_read),
    .bus_req_size(bus_req_size), .bus_req_fc(bus_req_fc),
    .bus_req_wdata(bus_req_wdata), .bus_done(bus_done), .bus_rdata(bus_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .q_empty(q_empty), .q_full(q_full),
    .q_level(q_level), .busy(busy), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] d0, d1, addr, cmd, rdata;
    logic [23:0] exp_addr;
    logic [1:0]  exp_size;
    logic        exp_read;
    logic [2:0]  exp_fc;
    logic [15:0] exp_wdata;
    logic        exp_rdv_issue;
    logic [31:0] exp_rd_data;
    logic        exp_rd_valid;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] d);
    pi_wr_stb = 1'b1; pi_reg = r; pi_wdata = d;
    tick();
    pi_wr_stb = 1'b0; pi_reg = 3'd0; pi_wdata = 16'h0;
  endtask

  task automatic accept();
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
  endtask

  task automatic done(input logic [15:0] d);
    bus_done = 1'b1; bus_rdata = d;
    tick();
    bus_done = 1'b0; bus_rdata = 16'h0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #2;
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_q_empty"}, 32'(q_empty), 32'd1);
    chk({tag, "_valid"}, 32'(bus_req_valid), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_q_level"}, 32'(q_level), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
  endtask

  initial begin
    // d0, d1, addr, cmd, rdata | addr, size, read, fc, wdata, rd_valid at issue, rd_data, rd_valid
    vecs[0] = '{16'hBEEF, 16'h0000, 16'h1234, 16'h29DF, 16'h0000,
                24'hDF1234, 2'd1, 1'b0, 3'd5, 16'hBEEF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{16'h0055, 16'h0000, 16'h0001, 16'h3C10, 16'hA5A5,
                24'h100001, 2'd0, 1'b1, 3'd7, 16'h0055, 1'b0, 32'h0000_A5A5, 1'b1};
    vecs[2] = '{16'h1357, 16'h9999, 16'hFFFF, 16'h13AB, 16'hEEEE,
                24'hABFFFF, 2'd1, 1'b0, 3'd2, 16'h1357, 1'b1, 32'h0000_A5A5, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h7777, 16'h8000, 16'h0500, 16'h5A5A,
                24'h008000, 2'd1, 1'b1, 3'd0, 16'hFFFF, 1'b0, 32'h0000_5A5A, 1'b1};

    sys_rst_n = 1'b0; pi_wr_stb = 1'b0; pi_reg = 3'd0; pi_wdata = 16'h0;
    bus_req_ready = 1'b0; bus_done = 1'b0; bus_rdata = 16'h0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
    chk_idle_reset("reset");
    chk("reset_q_full", 32'(q_full), 32'd0);

    for (int i = 0; i < 4; i++) begin
      wr(3'd0, vecs[i].d0);
      wr(3'd1, vecs[i].d1);
      wr(3'd2, vecs[i].addr);
      wr(3'd3, vecs[i].cmd);
      chk($sformatf("v%0d_q_empty_c1", i), 32'(q_empty), 32'd0);
      chk($sformatf("v%0d_valid_c1", i), 32'(bus_req_valid), 32'd0);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(bus_req_valid), 32'd1);
      chk($sformatf("v%0d_addr", i), 32'(bus_req_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_size", i), 32'(bus_req_size), 32'(vecs[i].exp_size));
      chk($sformatf("v%0d_read", i), 32'(bus_req_read), 32'(vecs[i].exp_read));
      chk($sformatf("v%0d_fc", i), 32'(bus_req_fc), 32'(vecs[i].exp_fc));
      chk($sformatf("v%0d_wdata", i), 32'(bus_req_wdata), 32'(vecs[i].exp_wdata));
      chk($sformatf("v%0d_rdv_issue", i), 32'(rd_valid), 32'(vecs[i].exp_rdv_issue));
      accept();
      chk($sformatf("v%0d_valid_wait", i), 32'(bus_req_valid), 32'd0);
      done(vecs[i].rdata);
      chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_rd_data);
      chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rd_valid));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      $display("vec %0d: addr=0x%06h size=%0d read=%0d fc=%0d wdata=0x%04h rd_data=0x%08h",
               i, bus_req_addr, bus_req_size, bus_req_read, bus_req_fc, bus_req_wdata, rd_data);
    end

    // Longword read crossing the top of the address space.
    wr(3'd2, 16'hFFFE);
    wr(3'd3, 16'h0EFF);
    tick();
    chk("lr_valid0", 32'(bus_req_valid), 32'd1);
    chk("lr_addr0", 32'(bus_req_addr), 32'h00FF_FFFE);
    chk("lr_size0", 32'(bus_req_size), 32'd1);
    chk("lr_fc0", 32'(bus_req_fc), 32'd1);
    chk("lr_rdv0", 32'(rd_valid), 32'd0);
    accept();
    done(16'h1122);
`ifdef PI_REQ_LONG_SPLIT_EN
    chk("lr_valid1", 32'(bus_req_valid), 32'd1);
    chk("lr_addr1", 32'(bus_req_addr), 32'h0000_0000);
    chk("lr_rdv1", 32'(rd_valid), 32'd0);
    accept();
    done(16'h3344);
    chk("lr_rd_data", rd_data, 32'h1122_3344);
`else
    chk("lr_rd_data", rd_data, 32'h0000_1122);
`endif
    chk("lr_rd_valid", 32'(rd_valid), 32'd1);
    chk("lr_busy", 32'(busy), 32'd0);
    $display("long read: rd_data=0x%08h rd_valid=%0d", rd_data, rd_valid);

    // Longword write: read result must survive write completions.
    wr(3'd0, 16'hCCDD);
    wr(3'd1, 16'hAABB);
    wr(3'd2, 16'h0100);
    wr(3'd3, 16'h0200);
    tick();
    chk("lw_addr0", 32'(bus_req_addr), 32'h0000_0100);
    chk("lw_size0", 32'(bus_req_size), 32'd1);
`ifdef PI_REQ_LONG_SPLIT_EN
    chk("lw_wdata0", 32'(bus_req_wdata), 32'h0000_AABB);
    accept();
    done(16'h0000);
    chk("lw_valid1", 32'(bus_req_valid), 32'd1);
    chk("lw_addr1", 32'(bus_req_addr), 32'h0000_0102);
    chk("lw_wdata1", 32'(bus_req_wdata), 32'h0000_CCDD);
    accept();
    done(16'h0000);
    chk("lw_rd_data", rd_data, 32'h1122_3344);
`else
    chk("lw_wdata0", 32'(bus_req_wdata), 32'h0000_CCDD);
    accept();
    done(16'h0000);
    chk("lw_rd_data", rd_data, 32'h0000_1122);
`endif
    chk("lw_busy", 32'(busy), 32'd0);
    chk("lw_rd_valid", 32'(rd_valid), 32'd1);
    $display("long write: done, rd_data=0x%08h", rd_data);

    // Overflow: one request stalls in ISSUE, four fill the FIFO, the sixth is dropped.
    for (int k = 0; k < 5; k++) wr(3'd3, 16'h0100);
    chk("ov_level5", 32'(q_level), 32'd4);
    chk("ov_full5", 32'(q_full), 32'd1);
    chk("ov_flag5", 32'(overflow), 32'd0);
    chk("ov_valid5", 32'(bus_req_valid), 32'd1);
    wr(3'd3, 16'h0100);
    chk("ov_level6", 32'(q_level), 32'd4);
    chk("ov_flag6", 32'(overflow), 32'd1);
    wr(3'd4, 16'hFFFF);
    chk("ov_flag_reg4", 32'(overflow), 32'd1);
    wr(3'd5, 16'h0000);
    chk("ov_clear", 32'(overflow), 32'd0);
    accept();
    done(16'h0000);
    chk("ov_full_idle", 32'(q_full), 32'd1);
    wr(3'd3, 16'h0100);
    chk("ov_simul_level", 32'(q_level), 32'd4);
    chk("ov_simul_flag", 32'(overflow), 32'd0);
    chk("ov_simul_valid", 32'(bus_req_valid), 32'd1);
    $display("overflow: level=%0d full=%0d overflow=%0d", q_level, q_full, overflow);

    // Reset during the WAIT phase of a longword read.
    do_reset();
    wr(3'd2, 16'hFFFE);
    wr(3'd3, 16'h0EFF);
    tick();
    accept();
    chk("mr_busy_wait", 32'(busy), 32'd1);
    do_reset();
    chk_idle_reset("mr_reset");
    done(16'h5555);
    chk("mr_rd_valid", 32'(rd_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_valid", 32'(bus_req_valid), 32'd0);
    $display("mid-op reset: rd_valid=%0d busy=%0d", rd_valid, busy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
